// File: rtl/exu_fpu_wb_ctl.sv
// FPU result writeback buffer.
// Holds completed FPU results in a small FIFO, drains them to the FP regfile
// write port under valid/ready, and accrues sticky fflags only from results
// that actually retire. Flushed results never touch fflags.
module exu_fpu_wb_ctl #(
   parameter int DEPTH = 2,
   parameter int RD_W  = 5
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            fpu_finish,
   input  logic [31:0]     fpu_result,
   input  logic [4:0]      fpu_status,
   input  logic [RD_W-1:0] fpu_rd,
   input  logic            flush_lower,
   input  logic            wb_ready,
   output logic            wb_valid,
   output logic [RD_W-1:0] wb_rd,
   output logic [31:0]     wb_data,
   input  logic            fcsr_wr_en,
   input  logic [4:0]      fcsr_wr_fflags,
   output logic [4:0]      fflags,
   output logic            wb_full,
   output logic            overflow
);

   localparam int AW = $clog2(DEPTH);
   localparam int PW = AW + 1;
   localparam logic [PW-1:0] C_DEPTH = PW'(DEPTH);

   logic [RD_W-1:0] r_rd     [DEPTH];
   logic [31:0]     r_data   [DEPTH];
   logic [4:0]      r_status [DEPTH];

   logic [PW-1:0]   r_wptr;
   logic [PW-1:0]   r_rptr;
   logic [4:0]      r_fflags;
   logic            r_overflow;

   logic [PW-1:0]   w_count;
   logic            w_empty;
   logic            w_full;
   logic            w_pop;
   logic            w_push;
   logic            w_drop;
   logic [AW-1:0]   w_head;
   logic [AW-1:0]   w_tail;
   logic [4:0]      w_fflags_base;
   logic [4:0]      w_fflags_next;

   assign w_count = r_wptr - r_rptr;
   assign w_empty = (w_count == '0);
   assign w_full  = (w_count == C_DEPTH);
   assign w_head  = r_rptr[AW-1:0];
   assign w_tail  = r_wptr[AW-1:0];

   // A pop frees a slot in the same cycle, so a full buffer can still accept.
   assign w_pop  = ~w_empty & wb_ready;
   assign w_push = fpu_finish & ~flush_lower & (~w_full | w_pop);
   assign w_drop = fpu_finish & ~flush_lower & w_full & ~w_pop;

   // CSR write and same-cycle retirement both land in the sticky flags.
   assign w_fflags_base = fcsr_wr_en ? fcsr_wr_fflags : r_fflags;
   assign w_fflags_next = w_fflags_base | (w_pop ? r_status[w_head] : 5'b00000);

   assign wb_valid = ~w_empty;
   assign wb_rd    = r_rd[w_head];
   assign wb_data  = r_data[w_head];
   assign wb_full  = w_full;
   assign fflags   = r_fflags;
   assign overflow = r_overflow;

   // Entry storage: written at the tail on an accepted push, no reset needed.
   always_ff @(posedge clk) begin
      if (w_push) begin
         r_rd[w_tail]     <= fpu_rd;
         r_data[w_tail]   <= fpu_result;
         r_status[w_tail] <= fpu_status;
      end
   end

   // Pointers: flush drops everything not retiring this cycle by catching rptr up to wptr.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_wptr <= '0;
         r_rptr <= '0;
      end else begin
         r_wptr <= r_wptr + {{AW{1'b0}}, w_push};
         if (flush_lower) begin
            r_rptr <= r_wptr;
         end else begin
            r_rptr <= r_rptr + {{AW{1'b0}}, w_pop};
         end
      end
   end

   // Sticky status: accrued flags and the dropped-result indicator.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_fflags   <= '0;
         r_overflow <= 1'b0;
      end else begin
         r_fflags <= w_fflags_next;
         if (w_drop) begin
            r_overflow <= 1'b1;
         end
      end
   end

endmodule

// File: tb/tb_exu_fpu_wb_ctl.sv
module tb_exu_fpu_wb_ctl;

   localparam int DEPTH = 2;
   localparam int RD_W  = 5;

   typedef struct {
      logic [RD_W-1:0] rd;
      logic [31:0]     data;
      logic [4:0]      st;
   } ent_t;

   logic            clk = 1'b0;
   logic            rst;
   logic            fpu_finish;
   logic [31:0]     fpu_result;
   logic [4:0]      fpu_status;
   logic [RD_W-1:0] fpu_rd;
   logic            flush_lower;
   logic            wb_ready;
   logic            wb_valid;
   logic [RD_W-1:0] wb_rd;
   logic [31:0]     wb_data;
   logic            fcsr_wr_en;
   logic [4:0]      fcsr_wr_fflags;
   logic [4:0]      fflags;
   logic            wb_full;
   logic            overflow;

   exu_fpu_wb_ctl #(.DEPTH(DEPTH), .RD_W(RD_W)) dut (
      .clk            (clk),
      .rst            (rst),
      .fpu_finish     (fpu_finish),
      .fpu_result     (fpu_result),
      .fpu_status     (fpu_status),
      .fpu_rd         (fpu_rd),
      .flush_lower    (flush_lower),
      .wb_ready       (wb_ready),
      .wb_valid       (wb_valid),
      .wb_rd          (wb_rd),
      .wb_data        (wb_data),
      .fcsr_wr_en     (fcsr_wr_en),
      .fcsr_wr_fflags (fcsr_wr_fflags),
      .fflags         (fflags),
      .wb_full        (wb_full),
      .overflow       (overflow)
   );

   always #5 clk = ~clk;

   // Reference model: queue of buffered results plus sticky state.
   ent_t       mdl_q[$];
   logic [4:0] mdl_ff;
   logic       mdl_ovf;

   // Expected writeback stream, consumed by the monitor.
   ent_t       sb_q[$];

   // Model snapshot for the cycle currently visible on the DUT outputs.
   logic       cur_valid;
   logic       cur_full;
   logic [4:0] cur_ff;
   logic       cur_ovf;
   ent_t       cur_head;
   logic       mon_en = 1'b0;

   int checks   = 0;
   int failures = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=0x%0h expected=0x%0h at %0t", name, act, exp, $time);
      end
   endtask

   // One cycle: snapshot model, drive inputs, advance model across the coming edge.
   task automatic step(input logic i_rst, input logic fin, input logic [RD_W-1:0] rd,
                       input logic [31:0] data, input logic [4:0] st, input logic fl,
                       input logic rdy, input logic csr_en, input logic [4:0] csr_v);
      ent_t e;
      @(posedge clk);
      #1;
      cur_valid = (mdl_q.size() != 0);
      cur_full  = (mdl_q.size() == DEPTH);
      cur_ff    = mdl_ff;
      cur_ovf   = mdl_ovf;
      if (mdl_q.size() != 0) cur_head = mdl_q[0];
      mon_en    = 1'b1;

      rst            = i_rst;
      fpu_finish     = fin;
      fpu_rd         = rd;
      fpu_result     = data;
      fpu_status     = st;
      flush_lower    = fl;
      wb_ready       = rdy;
      fcsr_wr_en     = csr_en;
      fcsr_wr_fflags = csr_v;

      if (i_rst) begin
         mdl_q.delete();
         mdl_ff  = '0;
         mdl_ovf = 1'b0;
      end else begin
         logic [4:0] ff_n;
         ff_n = csr_en ? csr_v : mdl_ff;
         if (mdl_q.size() != 0 && rdy) begin
            e = mdl_q.pop_front();
            sb_q.push_back(e);
            ff_n = ff_n | e.st;
         end
         mdl_ff = ff_n;
         if (fl) begin
            mdl_q.delete();
         end else if (fin) begin
            if (mdl_q.size() < DEPTH) begin
               e.rd = rd; e.data = data; e.st = st;
               mdl_q.push_back(e);
            end else begin
               mdl_ovf = 1'b1;
            end
         end
      end
   endtask

   task automatic idle(input logic rdy);
      step(1'b0, 1'b0, '0, 32'h0, 5'h0, 1'b0, rdy, 1'b0, 5'h0);
   endtask

   task automatic fin_op(input logic [RD_W-1:0] rd, input logic [31:0] data,
                         input logic [4:0] st, input logic rdy);
      step(1'b0, 1'b1, rd, data, st, 1'b0, rdy, 1'b0, 5'h0);
   endtask

   // Monitor: compares visible state and pops the scoreboard on each writeback.
   initial begin
      ent_t e;
      forever begin
         @(negedge clk);
         if (mon_en) begin
            chk("wb_valid", {31'b0, wb_valid}, {31'b0, cur_valid});
            chk("wb_full", {31'b0, wb_full}, {31'b0, cur_full});
            chk("fflags", {27'b0, fflags}, {27'b0, cur_ff});
            chk("overflow", {31'b0, overflow}, {31'b0, cur_ovf});
            if (cur_valid && wb_valid) begin
               chk("head_rd", {27'b0, wb_rd}, {27'b0, cur_head.rd});
               chk("head_data", wb_data, cur_head.data);
            end
            if (wb_valid && wb_ready && !rst) begin
               if (sb_q.size() == 0) begin
                  chk("wb_unexpected", 32'd1, 32'd0);
               end else begin
                  e = sb_q.pop_front();
                  chk("wb_rd", {27'b0, wb_rd}, {27'b0, e.rd});
                  chk("wb_data", wb_data, e.data);
               end
            end
         end
      end
   end

   initial begin
      mdl_ff  = '0;
      mdl_ovf = 1'b0;
      rst = 1'b1; fpu_finish = 1'b0; fpu_result = '0; fpu_status = '0; fpu_rd = '0;
      flush_lower = 1'b0; wb_ready = 1'b0; fcsr_wr_en = 1'b0; fcsr_wr_fflags = '0;

      step(1'b1, 1'b0, '0, 32'h0, 5'h0, 1'b0, 1'b0, 1'b0, 5'h0);
      step(1'b1, 1'b0, '0, 32'h0, 5'h0, 1'b0, 1'b1, 1'b0, 5'h0);

      // single op
      fin_op(5'd3, 32'h3F80_0000, 5'b00001, 1'b1);
      idle(1'b1);
      idle(1'b1);

      // backpressure, full, overflow, ordered drain
      fin_op(5'd1, 32'h1111_0001, 5'b00010, 1'b0);
      fin_op(5'd2, 32'h2222_0002, 5'b00000, 1'b0);
      fin_op(5'd4, 32'h4444_0004, 5'b10000, 1'b0);
      idle(1'b0);
      idle(1'b1);
      idle(1'b1);
      idle(1'b1);
      step(1'b1, 1'b0, '0, 32'h0, 5'h0, 1'b0, 1'b0, 1'b0, 5'h0);

      // full with simultaneous pop
      fin_op(5'd5, 32'h5555_0005, 5'b00000, 1'b0);
      fin_op(5'd6, 32'h6666_0006, 5'b00000, 1'b0);
      fin_op(5'd7, 32'h7777_0007, 5'b00001, 1'b1);
      idle(1'b0);
      idle(1'b1);
      idle(1'b1);
      idle(1'b1);
      step(1'b1, 1'b0, '0, 32'h0, 5'h0, 1'b0, 1'b0, 1'b0, 5'h0);

      // flush with same-cycle finish
      fin_op(5'd8, 32'h8888_0008, 5'b10000, 1'b0);
      fin_op(5'd9, 32'h9999_0009, 5'b01000, 1'b0);
      step(1'b0, 1'b1, 5'd10, 32'hAAAA_000A, 5'b00100, 1'b1, 1'b0, 1'b0, 5'h0);
      idle(1'b1);
      idle(1'b1);

      // CSR write colliding with retirement
      step(1'b0, 1'b0, '0, 32'h0, 5'h0, 1'b0, 1'b0, 1'b1, 5'b10000);
      fin_op(5'd11, 32'hBBBB_000B, 5'b00100, 1'b0);
      step(1'b0, 1'b0, '0, 32'h0, 5'h0, 1'b0, 1'b1, 1'b1, 5'b00000);
      idle(1'b1);

      // pointer wrap with back-to-back push/pop
      for (int i = 0; i < 10; i++) begin
         fin_op(5'(i + 12), 32'hC000_0000 + 32'(i), 5'(i % 3), 1'b1);
      end
      idle(1'b1);
      idle(1'b1);

      // randomized traffic
      for (int i = 0; i < 3000; i++) begin
         step(($urandom_range(0, 199) == 0),
              ($urandom_range(0, 1) == 1),
              5'($urandom),
              $urandom,
              5'($urandom),
              ($urandom_range(0, 19) == 0),
              ($urandom_range(0, 2) != 0),
              ($urandom_range(0, 9) == 0),
              5'($urandom));
      end
      idle(1'b1);
      idle(1'b1);
      idle(1'b1);

      @(negedge clk);
      #1;
      chk("sb_drained", sb_q.size(), 32'd0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/exu_fpu_wb_ctl.md
# exu_fpu_wb_ctl

FPU result writeback buffer sitting directly downstream of the FPU execution control. Captures each completed FPU result together with its destination register and exception status, queues it in a small FIFO, and drains it to the floating-point register file write port under a valid/ready handshake. Accumulates the sticky `fflags` field of `fcsr` from retired results only, so flushed results never set flags.

## Interface

Parameters:
- `DEPTH`, 2: FIFO entries; power of two, ≥ 2.
- `RD_W`, 5: destination register index width.

Ports:
- `clk`  in  1  core clock
- `rst`  in  1  synchronous, active-high reset
- `fpu_finish`  in  1  one-cycle pulse: FPU result valid this cycle
- `fpu_result`  in  32  FPU result data
- `fpu_status`  in  5  exception flags {NV,DZ,OF,UF,NX}
- `fpu_rd`  in  RD_W  destination FP register index
- `flush_lower`  in  1  pipeline flush; discards un-retired entries
- `wb_ready`  in  1  FP regfile write port granted this cycle
- `wb_valid`  out  1  head entry presented for writeback
- `wb_rd`  out  RD_W  head entry destination
- `wb_data`  out  32  head entry data
- `fcsr_wr_en`  in  1  CSR write to `fflags`/`fcsr`
- `fcsr_wr_fflags`  in  5  value written by CSR
- `fflags`  out  5  sticky accrued exception flags
- `wb_full`  out  1  FIFO full; upstream must not issue a new FPU op
- `overflow`  out  1  sticky: a `fpu_finish` was dropped

## Operation

- Storage: DEPTH entries of {rd, data[31:0], status[4:0]}; read/write pointers of log2(DEPTH)+1 bits; wrap at DEPTH; count = wptr − rptr (mod 2·DEPTH).
- push = `fpu_finish` & ~`flush_lower` & (~full | pop).
- pop = `wb_valid` & `wb_ready`.
- `wb_valid` = ~empty; `wb_rd`/`wb_data` driven from head entry (combinational from storage, registered storage).
- Push and pop in the same cycle: both take effect; count unchanged.
- Full, `fpu_finish` and pop in the same cycle: push accepted into the slot freed by pop.
- Full, `fpu_finish`, no pop: result dropped, `overflow` set to 1 and held until reset.
- Flush: after applying any same-cycle pop (that pop retires normally), rptr ← wptr (FIFO emptied); same-cycle `fpu_finish` is dropped and does not set `overflow`.
- fflags update: next = (`fcsr_wr_en` ? `fcsr_wr_fflags` : `fflags`) | (pop ? head.status : 0). The CSR write and a same-cycle retirement both take effect.
- Status of entries discarded by flush never reaches `fflags`.
- `wb_full` = (count == DEPTH).

## Timing

- Reset (`rst` high at a clock edge): pointers 0, `wb_valid`=0, `wb_full`=0, `fflags`=0, `overflow`=0; `wb_rd`/`wb_data` don't-care while `wb_valid`=0.
- Capture latency: `fpu_finish` at edge N → entry on `wb_valid`/`wb_data` from cycle N+1. No same-cycle bypass.
- Retire: pop at edge M → `fflags` reflects status at M+1; next entry (if any) presented at M+1.
- Throughput: one push and one pop per cycle sustained.
- `wb_valid` remains high and head data stable until `wb_ready`; `wb_ready` may be asserted independently of `wb_valid` (ignored when empty).
- Reset mid-operation discards all entries and flags; no writeback issued in the reset cycle.

## Test plan

- Single op: `fpu_finish` with rd=3, result=0x3F800000, status=5'b00001, `wb_ready`=1 → next cycle `wb_valid`=1, `wb_rd`=3, `wb_data`=0x3F800000; one cycle later `wb_valid`=0, `fflags`=5'b00001.
- Backpressure/full (DEPTH=2): two finishes, `wb_ready`=0 → `wb_full`=1; third finish without pop → `overflow`=1, queue holds first two; release `wb_ready` → entries drain in order.
- Full with simultaneous pop: full FIFO, `fpu_finish` (rd=7) and `wb_ready`=1 same cycle → head retires, rd=7 enqueued, `wb_full` stays 1, `overflow` stays 0.
- Flush: two entries with status NV and DZ queued, `wb_ready`=0, assert `flush_lower` → `wb_valid`=0 next cycle, `fflags`=0; same-cycle `fpu_finish` dropped.
- CSR/retire collision: `fflags`=5'b10000, `fcsr_wr_en` with 5'b00000 while retiring entry with status 5'b00100 → `fflags`=5'b00100.
- Pointer wrap: 10 back-to-back push/pop pairs with distinct data → outputs appear in order, count never exceeds 1, no `overflow`.
